// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 convolutional encoder (G1=7, G0=5) and a 4-state
// hard-decision Viterbi decoder with a register-exchange survivor memory.
module viterbi_codec #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_encoder_i,
    input  logic       encoder_i,
    output logic       valid_encoder_o,
    output logic [1:0] encoder_o,
    input  logic       enable_decoder_i,
    input  logic [1:0] decoder_i,
    output logic       valid_decoder_o,
    output logic       decoder_o
);

    localparam int CW = $clog2(TB_DEPTH + 1);

    // Hamming distance between the received symbol and the branch label
    function automatic logic [1:0] branch_metric(
        input logic [1:0] rx,
        input logic [1:0] p,
        input logic       b
    );
        logic [1:0] diff;
        diff = rx ^ {b ^ p[1] ^ p[0], b ^ p[0]};
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    logic [1:0] enc_s_q;
    logic [1:0] enc_sym_q;
    logic       enc_vld_q;

    logic [3:0][PM_W-1:0]     pm_q;
    logic [3:0][PM_W-1:0]     pm_d;
    logic [3:0][TB_DEPTH-1:0] sp_q;
    logic [3:0][TB_DEPTH-1:0] sp_d;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic                     dec_vld_q;
    logic                     dec_vld_d;
    logic                     dec_bit_q;
    logic                     dec_bit_d;

    logic [3:0][PM_W:0] cand0;
    logic [3:0][PM_W:0] cand1;
    logic [3:0][PM_W:0] acs;
    logic [3:0][1:0]    sel;
    logic [PM_W:0]      pm_min;
    logic [1:0]         best;

    // Encoder: shift the data bit into the 2-bit history and emit the symbol
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_s_q   <= 2'b00;
            enc_sym_q <= 2'b00;
            enc_vld_q <= 1'b0;
        end else if (enable_encoder_i) begin
            enc_sym_q <= {encoder_i ^ enc_s_q[1] ^ enc_s_q[0],
                          encoder_i ^ enc_s_q[0]};
            enc_s_q   <= {encoder_i, enc_s_q[1]};
            enc_vld_q <= 1'b1;
        end else begin
            enc_vld_q <= 1'b0;
        end
    end

    // Decoder datapath: ACS, normalisation, survivor exchange, best state
    always_comb begin
        cand0  = '0;
        cand1  = '0;
        acs    = '0;
        sel    = '0;
        pm_d   = '0;
        sp_d   = '0;
        pm_min = '0;
        best   = 2'd0;
        for (int n = 0; n < 4; n++) begin
            cand0[n] = {1'b0, pm_q[{n[0], 1'b0}]}
                     + {{(PM_W-1){1'b0}},
                        branch_metric(decoder_i, {n[0], 1'b0}, n[1])};
            cand1[n] = {1'b0, pm_q[{n[0], 1'b1}]}
                     + {{(PM_W-1){1'b0}},
                        branch_metric(decoder_i, {n[0], 1'b1}, n[1])};
            if (cand1[n] < cand0[n]) begin
                acs[n] = cand1[n];
                sel[n] = {n[0], 1'b1};
            end else begin
                acs[n] = cand0[n];
                sel[n] = {n[0], 1'b0};
            end
        end
        pm_min = acs[0];
        for (int n = 1; n < 4; n++) begin
            if (acs[n] < pm_min) begin
                pm_min = acs[n];
                best   = 2'(n);
            end
        end
        for (int n = 0; n < 4; n++) begin
            pm_d[n] = PM_W'(acs[n] - pm_min);
            sp_d[n] = (sp_q[sel[n]] << 1)
                    | {{(TB_DEPTH-1){1'b0}}, n[1]};
        end
        dec_bit_d = sp_d[best][TB_DEPTH-1];
        cnt_d     = (cnt_q == CW'(TB_DEPTH)) ? cnt_q : cnt_q + 1'b1;
        dec_vld_d = (cnt_q >= CW'(TB_DEPTH - 1));
    end

    // Decoder state: update only on consumed symbols, valid drops otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_q      <= {PM_W'(32), PM_W'(32), PM_W'(32), PM_W'(0)};
            sp_q      <= '0;
            cnt_q     <= '0;
            dec_vld_q <= 1'b0;
            dec_bit_q <= 1'b0;
        end else if (enable_decoder_i) begin
            pm_q      <= pm_d;
            sp_q      <= sp_d;
            cnt_q     <= cnt_d;
            dec_vld_q <= dec_vld_d;
            dec_bit_q <= dec_bit_d;
        end else begin
            dec_vld_q <= 1'b0;
        end
    end

    assign valid_encoder_o = enc_vld_q;
    assign encoder_o       = enc_sym_q;
    assign valid_decoder_o = dec_vld_q;
    assign decoder_o       = dec_bit_q;

endmodule

// File: tb/tb_viterbi_codec.sv
// Randomised bench for viterbi_codec: encoder vector, loopback decode
// with isolated/burst errors, enable gaps and mid-stream reset.
module tb_viterbi_codec;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable_encoder_i = 1'b0;
    logic       encoder_i = 1'b0;
    logic       valid_encoder_o;
    logic [1:0] encoder_o;
    logic       enable_decoder_i = 1'b0;
    logic [1:0] decoder_i = 2'b00;
    logic       valid_decoder_o;
    logic       decoder_o;

    int checks = 0;
    int errors = 0;
    bit src[$];
    bit rx[$];
    bit ref_rx[$];
    int enc_bad;
    int vbad;

    always #5 clk = ~clk;

    viterbi_codec #(.TB_DEPTH(D), .PM_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_encoder_i (enable_encoder_i),
        .encoder_i        (encoder_i),
        .valid_encoder_o  (valid_encoder_o),
        .encoder_o        (encoder_o),
        .enable_decoder_i (enable_decoder_i),
        .decoder_i        (decoder_i),
        .valid_decoder_o  (valid_decoder_o),
        .decoder_o        (decoder_o)
    );

    task automatic do_reset();
        enable_encoder_i = 1'b0;
        enable_decoder_i = 1'b0;
        encoder_i = 1'b0;
        decoder_i = 2'b00;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill_random(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(1'($urandom));
    endtask

    // Encoder fed from src; decoder fed the model symbol one clock later
    task automatic drive_stream(input int n, input bit gaps,
                                input int err_period, input int burst_at);
        bit h1 = 0;
        bit h2 = 0;
        bit have = 0;
        bit en_e;
        bit en_d;
        bit idle;
        bit [2:0] w;
        bit [1:0] pend = 2'b00;
        bit [1:0] exp_sym = 2'b00;
        int k = 0;
        int di = 0;
        int cyc = 0;
        rx.delete();
        enc_bad = 0;
        vbad = 0;
        while (k < n || have) begin
            idle = gaps && (cyc % 3 == 2);
            en_e = !idle && (k < n);
            en_d = !idle && have;
            enable_encoder_i = en_e;
            enable_decoder_i = en_d;
            if (en_e) begin
                encoder_i = src[k];
                w = {src[k], h1, h2};
                exp_sym = {^(w & 3'b111), ^(w & 3'b101)};
            end
            if (en_d) begin
                decoder_i = pend;
                if ((err_period > 0 && di % err_period == err_period / 2) ||
                    (burst_at >= 0 && di >= burst_at && di < burst_at + 4))
                    decoder_i[0] = ~pend[0];
            end
            @(posedge clk);
            #1;
            if (valid_encoder_o !== en_e) enc_bad++;
            if (en_e && encoder_o !== exp_sym) enc_bad++;
            if (valid_decoder_o) begin
                if (!en_d) vbad++;
                rx.push_back(decoder_o);
            end
            if (en_d) begin
                have = 0;
                di++;
            end
            if (en_e) begin
                pend = exp_sym;
                have = 1;
                h2 = h1;
                h1 = src[k];
                k++;
            end
            cyc++;
        end
        enable_encoder_i = 1'b0;
        enable_decoder_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({valid_encoder_o, encoder_o, valid_decoder_o, decoder_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000",
                     {valid_encoder_o, encoder_o, valid_decoder_o, decoder_o});
        end
        do_reset();
    endtask

    task automatic test_encoder_vector();
        bit       vin[5]  = '{1, 0, 0, 1, 1};
        bit [1:0] vout[5] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            enable_encoder_i = 1'b1;
            encoder_i = vin[i];
            @(posedge clk);
            #1;
            checks++;
            if (encoder_o !== vout[i] || valid_encoder_o !== 1'b1) begin
                errors++;
                $display("FAIL enc_vec[%0d] got %b/%b want %b/1",
                         i, encoder_o, valid_encoder_o, vout[i]);
            end
        end
        enable_encoder_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (encoder_o !== 2'b01 || valid_encoder_o !== 1'b0) begin
            errors++;
            $display("FAIL enc_hold got %b/%b want 01/0",
                     encoder_o, valid_encoder_o);
        end
        enable_encoder_i = 1'b1;
        encoder_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (encoder_o !== 2'b10 || valid_encoder_o !== 1'b1) begin
            errors++;
            $display("FAIL enc_resume got %b/%b want 10/1",
                     encoder_o, valid_encoder_o);
        end
        enable_encoder_i = 1'b0;
    endtask

    task automatic test_loopback_clean();
        do_reset();
        fill_random(256);
        drive_stream(256, 1'b0, 0, -1);
        checks++;
        if (enc_bad != 0) begin
            errors++;
            $display("FAIL clean_encoder got %0d bad want 0", enc_bad);
        end
        checks++;
        if (rx.size() != 256 - D + 1) begin
            errors++;
            $display("FAIL clean_count got %0d want %0d", rx.size(), 256 - D + 1);
        end
        for (int i = 0; i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== src[i]) begin
                errors++;
                $display("FAIL clean_bit[%0d] got %0d want %0d", i, rx[i], src[i]);
            end
        end
    endtask

    task automatic test_isolated_errors();
        do_reset();
        fill_random(256);
        drive_stream(256, 1'b0, 32, -1);
        checks++;
        if (rx.size() != 256 - D + 1) begin
            errors++;
            $display("FAIL iso_count got %0d want %0d", rx.size(), 256 - D + 1);
        end
        for (int i = 0; i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== src[i]) begin
                errors++;
                $display("FAIL iso_bit[%0d] got %0d want %0d", i, rx[i], src[i]);
            end
        end
    endtask

    task automatic test_burst();
        int bad = 0;
        int first = -1;
        int last = -1;
        int tail_bad = 0;
        do_reset();
        fill_random(256);
        drive_stream(256, 1'b0, 0, 100);
        for (int i = 0; i < rx.size(); i++) begin
            if (rx[i] !== src[i]) begin
                bad++;
                if (first < 0) first = i;
                last = i;
                if (i >= rx.size() - 64) tail_bad++;
            end
        end
        checks++;
        if (rx.size() != 256 - D + 1) begin
            errors++;
            $display("FAIL burst_count got %0d want %0d", rx.size(), 256 - D + 1);
        end
        checks++;
        if (bad > D || (bad > 0 && last - first >= D)) begin
            errors++;
            $display("FAIL burst_confined got %0d errs span %0d..%0d want <=%0d",
                     bad, first, last, D);
        end
        checks++;
        if (tail_bad != 0) begin
            errors++;
            $display("FAIL burst_resync got %0d tail errs want 0", tail_bad);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        fill_random(120);
        drive_stream(120, 1'b0, 0, -1);
        ref_rx = rx;
        do_reset();
        drive_stream(120, 1'b1, 0, -1);
        checks++;
        if (vbad != 0 || enc_bad != 0) begin
            errors++;
            $display("FAIL gap_valid got %0d/%0d stray want 0/0", vbad, enc_bad);
        end
        checks++;
        if (rx.size() != ref_rx.size()) begin
            errors++;
            $display("FAIL gap_count got %0d want %0d", rx.size(), ref_rx.size());
        end
        for (int i = 0; i < rx.size() && i < ref_rx.size(); i++) begin
            checks++;
            if (rx[i] !== ref_rx[i] || rx[i] !== src[i]) begin
                errors++;
                $display("FAIL gap_bit[%0d] got %0d want %0d", i, rx[i], src[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_random(100);
        drive_stream(100, 1'b0, 0, -1);
        enable_encoder_i = 1'b1;
        enable_decoder_i = 1'b1;
        encoder_i = 1'b1;
        decoder_i = 2'b11;
        @(posedge clk);
        #1;
        checks++;
        if (valid_encoder_o !== 1'b1 || valid_decoder_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_prevalid got %b/%b want 1/1",
                     valid_encoder_o, valid_decoder_o);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({valid_encoder_o, encoder_o, valid_decoder_o, decoder_o} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b want 00000",
                     {valid_encoder_o, encoder_o, valid_decoder_o, decoder_o});
        end
        enable_encoder_i = 1'b0;
        enable_decoder_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        src.delete();
        for (int i = 0; i < 40; i++) src.push_back(1'b0);
        drive_stream(40, 1'b0, 0, -1);
        checks++;
        if (rx.size() != 40 - D + 1) begin
            errors++;
            $display("FAIL mid_count got %0d want %0d", rx.size(), 40 - D + 1);
        end
        for (int i = 0; i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== 1'b0) begin
                errors++;
                $display("FAIL mid_zero[%0d] got %0d want 0", i, rx[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_encoder_vector();
        test_loopback_clean();
        test_isolated_errors();
        test_burst();
        test_gaps();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
